spi_ram_burst: RTL

SPI_RAM_BURST -- requirements
Module: spi_ram_burst

---
 rtl/spi_ram_burst.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_ram_burst.sv
// SPI-fed command RAM: pointer-set / write / read commands against a single-port word memory.
// Optional build macro SPI_RAM_AUTO_INC_EN: accepted data commands post-increment their pointer.
module spi_ram_burst #(
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned ADDR_SIZE  = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH+1:0] din,
   input  logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  tx_valid,
   output logic                  cmd_err
);

   localparam int unsigned MEM_WORDS = 1 << ADDR_SIZE;

   localparam logic [1:0] CMD_SET_WR = 2'b00;
   localparam logic [1:0] CMD_WRITE  = 2'b01;
   localparam logic [1:0] CMD_SET_RD = 2'b10;
   localparam logic [1:0] CMD_READ   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  cmd_err_q, cmd_err_d;
   logic                  mem_we_c;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic [1:0]            cmd_c;
   logic [DATA_WIDTH-1:0] payload_c;
   logic [ADDR_SIZE-1:0]  addr_c;
   logic                  addr_ok_c;

   assign cmd_c     = din[DATA_WIDTH+1:DATA_WIDTH];
   assign payload_c = din[DATA_WIDTH-1:0];
   assign addr_c    = payload_c[ADDR_SIZE-1:0];
   assign addr_ok_c = (32'(addr_c) < MEM_DEPTH);

`ifdef SPI_RAM_AUTO_INC_EN
   // Wraps at the last populated word, not at the pointer width.
   function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
      return (32'(p) == MEM_DEPTH - 1) ? '0 : p + ADDR_SIZE'(1);
   endfunction
`endif

   // State, pointer and output registers; reset wins over any command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[wr_ptr_q] <= payload_c;
      end
   end

   // Next state and pointers.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (rx_valid) begin
         case (cmd_c)
            CMD_SET_WR: begin
               if (addr_ok_c) begin
                  wr_ptr_d = addr_c;
                  state_d  = ST_WR;
               end
            end
            CMD_SET_RD: begin
               if (addr_ok_c) begin
                  rd_ptr_d = addr_c;
                  state_d  = ST_RD;
               end
            end
`ifdef SPI_RAM_AUTO_INC_EN
            CMD_WRITE: begin
               if (state_q == ST_WR) begin
                  wr_ptr_d = ptr_inc(wr_ptr_q);
               end
            end
            CMD_READ: begin
               if (state_q == ST_RD) begin
                  rd_ptr_d = ptr_inc(rd_ptr_q);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Outputs and memory write strobe.
   always_comb begin
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      cmd_err_d  = 1'b0;
      mem_we_c   = 1'b0;
      if (rx_valid && !rst) begin
         case (cmd_c)
            CMD_SET_WR,
            CMD_SET_RD: cmd_err_d = !addr_ok_c;
            CMD_WRITE: begin
               if (state_q == ST_WR) mem_we_c  = 1'b1;
               else                  cmd_err_d = 1'b1;
            end
            CMD_READ: begin
               if (state_q == ST_RD) begin
                  dout_d     = mem_q[rd_ptr_q];
                  tx_valid_d = 1'b1;
               end else begin
                  cmd_err_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;
   assign cmd_err  = cmd_err_q;

endmodule
